// File: rtl/mem_bus_arb_pkg.sv
// Shared definitions for the single-port bus arbiter.
package mem_bus_arb_pkg;

  // Arbiter sequencer states
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUS_IF  = 2'd1,
    ARB_BUS_MEM = 2'd2
  } arb_state_e;

  // Bus control levels
  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  // All-lanes byte enable; sliced to the bus width (covers data buses up to 512 bits)
  localparam int unsigned BE_MAX_W = 64;
  localparam logic [BE_MAX_W-1:0] BE_ALL = '1;

endpackage

// File: rtl/mem_bus_arb_watchdog.sv
// Wait-state watchdog: counts stalled bus cycles and flags the abort limit.
module mem_bus_arb_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;

  // Counter: clear wins over enable; stops at the limit so it cannot wrap
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && !expired_c) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired_c = (count_q == LIMIT);

endmodule

// File: rtl/mem_bus_arb.sv
// Single-port bus arbiter/sequencer between fetch (IF) and load/store (MEM).
module mem_bus_arb
  import mem_bus_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_valid_o,
  input  logic                    mem_req_i,
  input  logic                    mem_we_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] mem_be_i,
  output logic [DATA_WIDTH-1:0]   mem_rdata_o,
  output logic                    mem_valid_o,
  output logic                    bus_ce_o,
  output logic                    bus_we_o,
  output logic [ADDR_WIDTH-1:0]   bus_addr_o,
  output logic [DATA_WIDTH-1:0]   bus_wdata_o,
  output logic [DATA_WIDTH/8-1:0] bus_be_o,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
  input  logic                    bus_ready_i,
  output logic                    stall_o,
  output logic                    err_o
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;
  localparam logic [BE_W-1:0] BE_FULL = BE_ALL[BE_W-1:0];

  arb_state_e            state_q, state_d;
  logic                  bus_ce_d, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_d;
  logic [BE_W-1:0]       bus_be_d;
  logic [DATA_WIDTH-1:0] if_rdata_d, mem_rdata_d;
  logic                  if_valid_d, mem_valid_d, err_d;
  logic                  mem_elig_c, if_elig_c;
  logic                  wd_clr_c, wd_en_c, wd_expired_c;

  // A requester still seeing its completion pulse is holding a stale request
  assign mem_elig_c = mem_req_i & ~mem_valid_o;
  assign if_elig_c  = if_req_i & ~if_valid_o;

  // Watchdog runs only while a bus access waits; cleared whenever we head to idle
  assign wd_clr_c = (state_d == ARB_IDLE);
  assign wd_en_c  = (state_q != ARB_IDLE) & ~bus_ready_i;

  mem_bus_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (wd_clr_c),
    .en_i      (wd_en_c),
    .expired_c (wd_expired_c)
  );

  // Stall while any request is outstanding; forced low in reset
  assign stall_o = rst_n_i & (mem_elig_c | if_elig_c);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    bus_ce_d    = bus_ce_o;
    bus_we_d    = bus_we_o;
    bus_addr_d  = bus_addr_o;
    bus_wdata_d = bus_wdata_o;
    bus_be_d    = bus_be_o;
    if_rdata_d  = if_rdata_o;
    mem_rdata_d = mem_rdata_o;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (mem_elig_c) begin
          state_d     = ARB_BUS_MEM;
          bus_ce_d    = CHIP_ENABLE;
          bus_we_d    = mem_we_i ? WRITE_ENABLE : WRITE_DISABLE;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_we_i ? mem_wdata_i : '0;
          bus_be_d    = mem_we_i ? mem_be_i : BE_FULL;
        end else if (if_elig_c) begin
          state_d     = ARB_BUS_IF;
          bus_ce_d    = CHIP_ENABLE;
          bus_we_d    = WRITE_DISABLE;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
          bus_be_d    = BE_FULL;
        end
      end

      ARB_BUS_IF, ARB_BUS_MEM: begin
        // Ready at the watchdog limit still counts as a normal completion
        if (bus_ready_i || wd_expired_c) begin
          state_d     = ARB_IDLE;
          bus_ce_d    = CHIP_DISABLE;
          bus_we_d    = WRITE_DISABLE;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          bus_be_d    = '0;
          err_d       = ~bus_ready_i;
          if (state_q == ARB_BUS_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus_ready_i ? bus_rdata_i : '0;
          end else begin
            mem_valid_d = 1'b1;
            mem_rdata_d = (bus_ready_i && !bus_we_o) ? bus_rdata_i : '0;
          end
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ARB_IDLE;
      bus_ce_o    <= CHIP_DISABLE;
      bus_we_o    <= WRITE_DISABLE;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_be_o    <= '0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
      if_valid_o  <= 1'b0;
      mem_valid_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_ce_o    <= bus_ce_d;
      bus_we_o    <= bus_we_d;
      bus_addr_o  <= bus_addr_d;
      bus_wdata_o <= bus_wdata_d;
      bus_be_o    <= bus_be_d;
      if_rdata_o  <= if_rdata_d;
      mem_rdata_o <= mem_rdata_d;
      if_valid_o  <= if_valid_d;
      mem_valid_o <= mem_valid_d;
      err_o       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed testbench for mem_bus_arb.
module tb_mem_bus_arb;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned TO = 16;

  logic          clk, rst_n;
  logic          if_req, if_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          mem_req, mem_we, mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [BW-1:0] mem_be;
  logic          bus_ce, bus_we, bus_ready, stall, err;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic [BW-1:0] bus_be;

  int vectors = 0;
  int miscompares = 0;

  mem_bus_arb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_rdata_o  (if_rdata),
    .if_valid_o  (if_valid),
    .mem_req_i   (mem_req),
    .mem_we_i    (mem_we),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_be_i    (mem_be),
    .mem_rdata_o (mem_rdata),
    .mem_valid_o (mem_valid),
    .bus_ce_o    (bus_ce),
    .bus_we_o    (bus_we),
    .bus_addr_o  (bus_addr),
    .bus_wdata_o (bus_wdata),
    .bus_be_o    (bus_be),
    .bus_rdata_i (bus_rdata),
    .bus_ready_i (bus_ready),
    .stall_o     (stall),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if_req = 1'b1; mem_req = 1'b1;
    step();
    vectors++; if (bus_ce !== 1'b0) begin miscompares++; $display("FAIL reset_bus_ce: got %0h want 0", bus_ce); end
    vectors++; if (bus_addr !== 32'h0) begin miscompares++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
    vectors++; if (if_valid !== 1'b0 || mem_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0h/%0h want 0/0", if_valid, mem_valid); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %0h want 0", err); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %0h want 0", stall); end
    vectors++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, mem_rdata); end
    if_req = 1'b0; mem_req = 1'b0;
    #2 rst_n = 1'b1;
    step();
    vectors++; if (bus_ce !== 1'b0 || stall !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle: got ce=%0h stall=%0h want 0/0", bus_ce, stall); end
  endtask

  task automatic test_if_only();
    if_req = 1'b1; if_addr = 32'h100; bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
    #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL if_stall_req: got %0h want 1", stall); end
    step();
    vectors++; if (bus_ce !== 1'b1) begin miscompares++; $display("FAIL if_ce: got %0h want 1", bus_ce); end
    vectors++; if (bus_addr !== 32'h100) begin miscompares++; $display("FAIL if_addr: got %h want 00000100", bus_addr); end
    vectors++; if (bus_be !== 4'hF || bus_we !== 1'b0) begin miscompares++; $display("FAIL if_be_we: got be=%h we=%0h want F/0", bus_be, bus_we); end
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL if_valid_early: got %0h want 0", if_valid); end
    step();
    vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL if_valid: got %0h want 1", if_valid); end
    vectors++; if (if_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL if_rdata: got %h want deadbeef", if_rdata); end
    vectors++; if (stall !== 1'b0 || bus_ce !== 1'b0) begin miscompares++; $display("FAIL if_done: got stall=%0h ce=%0h want 0/0", stall, bus_ce); end
    // request still held at the edge ending the pulse: must not be regranted
    step();
    vectors++; if (bus_ce !== 1'b0 || if_valid !== 1'b0) begin miscompares++; $display("FAIL if_no_regrant: got ce=%0h valid=%0h want 0/0", bus_ce, if_valid); end
    vectors++; if (if_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL if_rdata_hold: got %h want deadbeef", if_rdata); end
    if_req = 1'b0; bus_ready = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h300;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000; mem_be = 4'h3; mem_wdata = 32'hFFFF_FFFF;
    bus_ready = 1'b1; bus_rdata = 32'hAAAA0001;
    step();
    vectors++; if (bus_ce !== 1'b1 || bus_addr !== 32'h2000) begin miscompares++; $display("FAIL sim_mem_first: got ce=%0h addr=%h want 1/00002000", bus_ce, bus_addr); end
    vectors++; if (bus_be !== 4'hF || bus_we !== 1'b0) begin miscompares++; $display("FAIL sim_load_be: got be=%h we=%0h want F/0", bus_be, bus_we); end
    step();
    vectors++; if (mem_valid !== 1'b1 || if_valid !== 1'b0) begin miscompares++; $display("FAIL sim_mem_valid: got mem=%0h if=%0h want 1/0", mem_valid, if_valid); end
    vectors++; if (mem_rdata !== 32'hAAAA0001) begin miscompares++; $display("FAIL sim_mem_rdata: got %h want aaaa0001", mem_rdata); end
    vectors++; if (bus_ce !== 1'b0) begin miscompares++; $display("FAIL sim_idle_gap: got ce=%0h want 0", bus_ce); end
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL sim_stall_if: got %0h want 1", stall); end
    mem_req = 1'b0; bus_rdata = 32'hBBBB0002;
    step();
    vectors++; if (bus_ce !== 1'b1 || bus_addr !== 32'h300) begin miscompares++; $display("FAIL sim_if_second: got ce=%0h addr=%h want 1/00000300", bus_ce, bus_addr); end
    vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL sim_mem_pulse_len: got %0h want 0", mem_valid); end
    step();
    vectors++; if (if_valid !== 1'b1 || if_rdata !== 32'hBBBB0002) begin miscompares++; $display("FAIL sim_if_valid: got valid=%0h rdata=%h want 1/bbbb0002", if_valid, if_rdata); end
    vectors++; if (mem_rdata !== 32'hAAAA0001) begin miscompares++; $display("FAIL sim_mem_rdata_hold: got %h want aaaa0001", mem_rdata); end
    if_req = 1'b0; bus_ready = 1'b0;
    step();
  endtask

  task automatic test_store_byte();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2001; mem_wdata = 32'h0000AB00; mem_be = 4'b0010;
    bus_ready = 1'b1; bus_rdata = 32'hCAFEF00D;
    step();
    vectors++; if (bus_we !== 1'b1 || bus_be !== 4'b0010) begin miscompares++; $display("FAIL st_we_be: got we=%0h be=%h want 1/2", bus_we, bus_be); end
    vectors++; if (bus_wdata !== 32'h0000AB00 || bus_addr !== 32'h2001) begin miscompares++; $display("FAIL st_data_addr: got %h/%h want 0000ab00/00002001", bus_wdata, bus_addr); end
    step();
    vectors++; if (mem_valid !== 1'b1 || mem_rdata !== 32'h0) begin miscompares++; $display("FAIL st_done: got valid=%0h rdata=%h want 1/0", mem_valid, mem_rdata); end
    mem_req = 1'b0; mem_we = 1'b0; bus_ready = 1'b0;
    step();
  endtask

  task automatic test_wait_states();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3000; mem_be = 4'h1;
    bus_ready = 1'b0; bus_rdata = 32'h5A5A5A5A;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (bus_ce !== 1'b1 || bus_addr !== 32'h3000 || bus_be !== 4'hF || bus_we !== 1'b0 || mem_valid !== 1'b0 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL ws_stable[%0d]: got ce=%0h addr=%h be=%h we=%0h valid=%0h err=%0h want 1/00003000/F/0/0/0", i, bus_ce, bus_addr, bus_be, bus_we, mem_valid, err);
      end
      if (i == 5) bus_ready = 1'b1;
    end
    step();
    vectors++; if (mem_valid !== 1'b1 || mem_rdata !== 32'h5A5A5A5A || err !== 1'b0) begin miscompares++; $display("FAIL ws_done: got valid=%0h rdata=%h err=%0h want 1/5a5a5a5a/0", mem_valid, mem_rdata, err); end
    mem_req = 1'b0; bus_ready = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h4000; bus_ready = 1'b0; bus_rdata = 32'h77777777;
    for (int i = 0; i < int'(TO); i++) begin
      step();
      vectors++;
      if (bus_ce !== 1'b1 || mem_valid !== 1'b0 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL to_wait[%0d]: got ce=%0h valid=%0h err=%0h want 1/0/0", i, bus_ce, mem_valid, err);
      end
    end
    step();
    vectors++; if (mem_valid !== 1'b1 || err !== 1'b1) begin miscompares++; $display("FAIL to_abort: got valid=%0h err=%0h want 1/1", mem_valid, err); end
    vectors++; if (mem_rdata !== 32'h0 || bus_ce !== 1'b0) begin miscompares++; $display("FAIL to_abort_data: got rdata=%h ce=%0h want 0/0", mem_rdata, bus_ce); end
    mem_req = 1'b0;
    step();
    vectors++; if (err !== 1'b0 || mem_valid !== 1'b0 || bus_ce !== 1'b0) begin miscompares++; $display("FAIL to_idle: got err=%0h valid=%0h ce=%0h want 0/0/0", err, mem_valid, bus_ce); end
    // ready arriving in the limit cycle completes normally
    mem_req = 1'b1; mem_addr = 32'h4004;
    for (int i = 0; i < int'(TO); i++) begin
      step();
      if (i == int'(TO) - 1) bus_ready = 1'b1;
    end
    step();
    vectors++; if (mem_valid !== 1'b1 || err !== 1'b0 || mem_rdata !== 32'h77777777) begin miscompares++; $display("FAIL to_ready_wins: got valid=%0h err=%0h rdata=%h want 1/0/77777777", mem_valid, err, mem_rdata); end
    mem_req = 1'b0; bus_ready = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h5000; bus_ready = 1'b0;
    step();
    vectors++; if (bus_ce !== 1'b1 || bus_addr !== 32'h5000) begin miscompares++; $display("FAIL ar_started: got ce=%0h addr=%h want 1/00005000", bus_ce, bus_addr); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus_ce !== 1'b0 || bus_addr !== 32'h0) begin miscompares++; $display("FAIL ar_bus_clear: got ce=%0h addr=%h want 0/0", bus_ce, bus_addr); end
    vectors++; if (mem_valid !== 1'b0 || err !== 1'b0 || stall !== 1'b0) begin miscompares++; $display("FAIL ar_flags: got valid=%0h err=%0h stall=%0h want 0/0/0", mem_valid, err, stall); end
    vectors++; if (mem_rdata !== 32'h0) begin miscompares++; $display("FAIL ar_rdata: got %h want 0", mem_rdata); end
    mem_req = 1'b0;
    step();
    #2 rst_n = 1'b1;
    step();
    vectors++; if (mem_valid !== 1'b0 || bus_ce !== 1'b0) begin miscompares++; $display("FAIL ar_no_pulse: got valid=%0h ce=%0h want 0/0", mem_valid, bus_ce); end
    if_req = 1'b1; if_addr = 32'h600; bus_ready = 1'b1; bus_rdata = 32'h12345678;
    step();
    vectors++; if (bus_ce !== 1'b1 || bus_addr !== 32'h600) begin miscompares++; $display("FAIL ar_if_grant: got ce=%0h addr=%h want 1/00000600", bus_ce, bus_addr); end
    step();
    vectors++; if (if_valid !== 1'b1 || if_rdata !== 32'h12345678 || err !== 1'b0) begin miscompares++; $display("FAIL ar_if_done: got valid=%0h rdata=%h err=%0h want 1/12345678/0", if_valid, if_rdata, err); end
    if_req = 1'b0; bus_ready = 1'b0;
    step();
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL ar_if_pulse_len: got %0h want 0", if_valid); end
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
    bus_rdata = '0; bus_ready = 1'b0;
    test_reset();
    test_if_only();
    test_simultaneous();
    test_store_byte();
    test_wait_states();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
